hazard_ctrl: RTL

Pipeline hazard and forwarding controller for the 5-stage CPU pipeline. It reads the decode-stage source operands and the control fields leaving the ID/EX, EX/MEM and MEM/WB registers. It drives stall, bubble and flush controls back into the fetch and pipeline registers, plus registered forwarding selects for the EX-stage ALU operand muxes. A small FSM handles load-use stalls, branch/jump redirect flushes and memory wait freezes.

---
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline control fields in, stall/flush/forward out.
// master is the pipeline datapath side, slave is the controller.
interface hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_srcA;
    logic [REG_W-1:0] id_srcB;
    logic             id_useA;
    logic             id_useB;

    logic [REG_W-1:0] ex_destReg;
    logic             ex_wreg;
    logic             ex_rmem;
    logic             ex_wpc;
    logic             ex_jmp;
    logic             ex_taken;

    logic [REG_W-1:0] mem_destReg;
    logic             mem_wreg;
    logic             mem_rmem;
    logic             mem_wmem;
    logic             mem_ready;

    logic             stall_pc;
    logic             stall_ifid;
    logic             bubble_idex;
    logic             flush_ifid;
    logic             flush_idex;
    logic             freeze;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_srcA, id_srcB, id_useA, id_useB,
        output ex_destReg, ex_wreg, ex_rmem, ex_wpc, ex_jmp, ex_taken,
        output mem_destReg, mem_wreg, mem_rmem, mem_wmem, mem_ready,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex,
        input  freeze, fwdA, fwdB, state, stall_cnt
    );

    modport slave (
        input  id_valid, id_srcA, id_srcB, id_useA, id_useB,
        input  ex_destReg, ex_wreg, ex_rmem, ex_wpc, ex_jmp, ex_taken,
        input  mem_destReg, mem_wreg, mem_rmem, mem_wmem, mem_ready,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex,
        output freeze, fwdA, fwdB, state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, redirect flush, memory-wait freeze and EX forwarding
// control for the 5-stage pipeline.
module hazard_ctrl #(
    parameter int FETCH_LAT = 1,
    parameter int REG_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } state_t;

    localparam bit         GO_FLUSH   = (FETCH_LAT > 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FETCH_LAT - 1);

    state_t           st_q;
    logic [2:0]       fcnt_q;
    logic [1:0]       fwdA_q;
    logic [1:0]       fwdB_q;
    logic [CNT_W-1:0] cnt_q;

    logic   memwait;
    logic   redirect;
    logic   hitA;
    logic   hitB;
    logic   loaduse;
    logic   in_flush;
    logic   ld_stall;
    logic   stall;
    logic   [1:0] selA;
    logic   [1:0] selB;
    state_t st_rep;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] exd,
        input logic             exw,
        input logic             exr,
        input logic [REG_W-1:0] memd,
        input logic             memw
    );
        logic [1:0] s;
        s = 2'd0;
        if (exw && !exr && src == exd)
            s = 2'd1;
        else if (memw && src == memd)
            s = 2'd2;
        return s;
    endfunction

    always_comb begin
        memwait  = (bus.mem_rmem | bus.mem_wmem) & ~bus.mem_ready;
        redirect = bus.ex_wpc | (bus.ex_jmp & bus.ex_taken);
        hitA     = bus.id_useA & (bus.id_srcA == bus.ex_destReg);
        hitB     = bus.id_useB & (bus.id_srcB == bus.ex_destReg);
        loaduse  = bus.id_valid & bus.ex_rmem & bus.ex_wreg & (hitA | hitB);
        in_flush = (st_q == FLUSH);
        // Memwait masks everything; a redirect kills any pending load-use.
        ld_stall = ~memwait & ~redirect & ~in_flush & loaduse;
        stall    = memwait | ld_stall;

        selA = fwd_sel(bus.id_srcA, bus.ex_destReg, bus.ex_wreg,
                       bus.ex_rmem, bus.mem_destReg, bus.mem_wreg);
        selB = fwd_sel(bus.id_srcB, bus.ex_destReg, bus.ex_wreg,
                       bus.ex_rmem, bus.mem_destReg, bus.mem_wreg);

        st_rep = RUN;
        unique case (1'b1)
            memwait:              st_rep = MEMWAIT;
            (~memwait & in_flush): st_rep = FLUSH;
            ld_stall:             st_rep = LDSTALL;
            default:              st_rep = RUN;
        endcase

        bus.freeze      = memwait;
        bus.stall_pc    = stall;
        bus.stall_ifid  = ld_stall;
        bus.bubble_idex = ld_stall;
        bus.flush_idex  = ~memwait & redirect;
        bus.flush_ifid  = ~memwait & (redirect | in_flush);
        bus.fwdA        = fwdA_q;
        bus.fwdB        = fwdB_q;
        bus.state       = st_rep;
        bus.stall_cnt   = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= RUN;
            fcnt_q <= 3'd0;
            fwdA_q <= 2'd0;
            fwdB_q <= 2'd0;
            cnt_q  <= '0;
        end else begin
            if (stall && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            if (!memwait) begin
                if (redirect) begin
                    fwdA_q <= 2'd0;
                    fwdB_q <= 2'd0;
                    if (GO_FLUSH) begin
                        st_q   <= FLUSH;
                        fcnt_q <= FLUSH_INIT;
                    end else begin
                        st_q   <= RUN;
                        fcnt_q <= 3'd0;
                    end
                end else if (in_flush) begin
                    fcnt_q <= fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1)
                        st_q <= RUN;
                    fwdA_q <= selA;
                    fwdB_q <= selB;
                end else if (ld_stall) begin
                    fwdA_q <= 2'd0;
                    fwdB_q <= 2'd0;
                end else begin
                    fwdA_q <= selA;
                    fwdB_q <= selB;
                end
            end
        end
    end
endmodule
